// File: rtl/openddr_pkg.sv
// rtl/openddr_pkg.sv - shared DFI constants, phase-vector type and helpers
package openddr_pkg;

    localparam int DFI_PHASES = 4;
    localparam logic [7:0] DFI_UNDERFLOW_BYTE = 8'hEE;
    localparam logic [7:0] DFI_MASK_FILL_BYTE = 8'h00;

    typedef logic [DFI_PHASES-1:0] dfi_phase_t;

    function automatic logic [2:0] dfi_popcount(input dfi_phase_t v);
        logic [2:0] n;
        n = '0;
        for (int p = 0; p < DFI_PHASES; p++) begin
            n = n + 3'(v[p]);
        end
        return n;
    endfunction

endpackage

// File: rtl/openddr_dfi_rdlat_delay.sv
// rtl/openddr_dfi_rdlat_delay.sv - variable-tap delay line turning read enables into read valids
module openddr_dfi_rdlat_delay
    import openddr_pkg::*;
#(
    parameter int MAX_RDLAT = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_cfg_rdlat,
    input  dfi_phase_t i_en,
    output dfi_phase_t o_vld,
    output logic       o_inflight
);

    localparam int LW = $clog2(MAX_RDLAT + 1);

    dfi_phase_t      r_stage [MAX_RDLAT];
    logic [LW-1:0]   r_rdlat;
    logic [LW-1:0]   w_clamped;
    logic [LW-1:0]   w_tap;
    logic            w_busy;

    always_comb begin
        w_clamped = LW'(i_cfg_rdlat);
        if (i_cfg_rdlat == '0) begin
            w_clamped = LW'(1);
        end else if (int'(i_cfg_rdlat) > MAX_RDLAT) begin
            w_clamped = LW'(MAX_RDLAT);
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < MAX_RDLAT; i++) begin
            w_busy = w_busy | (r_stage[i] != '0);
        end
    end

    assign w_tap      = r_rdlat - LW'(1);
    assign o_vld      = r_stage[w_tap];
    assign o_inflight = w_busy;

    // Stages past the tap are zeroed so consumed vectors never keep o_inflight high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < MAX_RDLAT; i++) begin
                r_stage[i] <= '0;
            end
            r_rdlat <= LW'(1);
        end else begin
            r_stage[0] <= i_en;
            for (int i = 1; i < MAX_RDLAT; i++) begin
                r_stage[i] <= (i < int'(r_rdlat)) ? r_stage[i-1] : '0;
            end
            if (!w_busy && (i_en == '0)) begin
                r_rdlat <= w_clamped;
            end
        end
    end

endmodule

// File: rtl/openddr_dfi_phy_responder.sv
// rtl/openddr_dfi_phy_responder.sv - DFI PHY stand-in looping masked write beats back as read data
module openddr_dfi_phy_responder
    import openddr_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int MAX_RDLAT  = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 cfg_rdlat,
    input  logic                       err_clr,
    input  logic [DATA_WIDTH-1:0]      dfi_wrdata_0_p0,
    input  logic [DATA_WIDTH-1:0]      dfi_wrdata_0_p1,
    input  logic [DATA_WIDTH-1:0]      dfi_wrdata_1_p2,
    input  logic [DATA_WIDTH-1:0]      dfi_wrdata_1_p3,
    input  logic [DATA_WIDTH/8-1:0]    dfi_wrdata_mask_0_p0,
    input  logic [DATA_WIDTH/8-1:0]    dfi_wrdata_mask_0_p1,
    input  logic [DATA_WIDTH/8-1:0]    dfi_wrdata_mask_1_p2,
    input  logic [DATA_WIDTH/8-1:0]    dfi_wrdata_mask_1_p3,
    input  logic                       dfi_wrdata_en_0_p0,
    input  logic                       dfi_wrdata_en_0_p1,
    input  logic                       dfi_wrdata_en_1_p2,
    input  logic                       dfi_wrdata_en_1_p3,
    input  logic                       dfi_rddata_en_0_p0,
    input  logic                       dfi_rddata_en_0_p1,
    input  logic                       dfi_rddata_en_1_p2,
    input  logic                       dfi_rddata_en_1_p3,
    output logic [DATA_WIDTH-1:0]      dfi_rddata_0_p0,
    output logic [DATA_WIDTH-1:0]      dfi_rddata_0_p1,
    output logic [DATA_WIDTH-1:0]      dfi_rddata_1_p2,
    output logic [DATA_WIDTH-1:0]      dfi_rddata_1_p3,
    output logic                       dfi_rddata_valid_0_p0,
    output logic                       dfi_rddata_valid_0_p1,
    output logic                       dfi_rddata_valid_1_p2,
    output logic                       dfi_rddata_valid_1_p3,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       rd_inflight,
    output logic                       overflow_err,
    output logic                       underflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] w_wr_data [DFI_PHASES];
    logic [NB-1:0]         w_wr_mask [DFI_PHASES];
    logic [DATA_WIDTH-1:0] w_beat    [DFI_PHASES];
    logic [AW-1:0]         w_wr_addr [DFI_PHASES];
    logic [AW-1:0]         w_rd_addr [DFI_PHASES];
    dfi_phase_t            w_wr_en;
    dfi_phase_t            w_rd_en;
    dfi_phase_t            w_rd_vld;
    dfi_phase_t            w_pop_hit;
    logic [2:0]            w_wr_num;
    logic [2:0]            w_wr_ofs;
    logic [2:0]            w_pop_num;
    logic [CW-1:0]         w_free;
    logic                  w_wr_ok;
    logic                  w_underflow;

    logic [DATA_WIDTH-1:0] r_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] r_rddata [DFI_PHASES];
    dfi_phase_t            r_rdvld;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    assign w_wr_data[0] = dfi_wrdata_0_p0;
    assign w_wr_data[1] = dfi_wrdata_0_p1;
    assign w_wr_data[2] = dfi_wrdata_1_p2;
    assign w_wr_data[3] = dfi_wrdata_1_p3;
    assign w_wr_mask[0] = dfi_wrdata_mask_0_p0;
    assign w_wr_mask[1] = dfi_wrdata_mask_0_p1;
    assign w_wr_mask[2] = dfi_wrdata_mask_1_p2;
    assign w_wr_mask[3] = dfi_wrdata_mask_1_p3;
    assign w_wr_en = {dfi_wrdata_en_1_p3, dfi_wrdata_en_1_p2, dfi_wrdata_en_0_p1, dfi_wrdata_en_0_p0};
    assign w_rd_en = {dfi_rddata_en_1_p3, dfi_rddata_en_1_p2, dfi_rddata_en_0_p1, dfi_rddata_en_0_p0};

    openddr_dfi_rdlat_delay #(
        .MAX_RDLAT (MAX_RDLAT)
    ) u_rdlat_delay (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cfg_rdlat (cfg_rdlat),
        .i_en        (w_rd_en),
        .o_vld       (w_rd_vld),
        .o_inflight  (rd_inflight)
    );

    always_comb begin
        for (int p = 0; p < DFI_PHASES; p++) begin
            w_beat[p] = w_wr_data[p];
            for (int b = 0; b < NB; b++) begin
                if (w_wr_mask[p][b]) begin
                    w_beat[p][8*b +: 8] = DFI_MASK_FILL_BYTE;
                end
            end
        end
    end

    assign w_wr_num = dfi_popcount(w_wr_en);
    assign w_free   = CW'(DEPTH) - r_count;
    assign w_wr_ok  = CW'(w_wr_num) <= w_free;

    // Both pushes and pops are judged against occupancy at cycle start.
    always_comb begin
        w_wr_ofs  = '0;
        w_pop_num = '0;
        w_pop_hit = '0;
        for (int p = 0; p < DFI_PHASES; p++) begin
            w_wr_addr[p] = r_wr_ptr + AW'(w_wr_ofs);
            w_wr_ofs     = w_wr_ofs + 3'(w_wr_en[p]);
            w_rd_addr[p] = r_rd_ptr + AW'(w_pop_num);
            if (w_rd_vld[p] && (r_count > CW'(w_pop_num))) begin
                w_pop_hit[p] = 1'b1;
                w_pop_num    = w_pop_num + 3'd1;
            end
        end
    end

    assign w_underflow = (w_rd_vld & ~w_pop_hit) != '0;

    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            for (int p = 0; p < DFI_PHASES; p++) begin
                if (w_wr_en[p]) begin
                    r_mem[w_wr_addr[p]] <= w_beat[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rdvld     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            for (int p = 0; p < DFI_PHASES; p++) begin
                r_rddata[p] <= '0;
            end
        end else begin
            r_wr_ptr <= r_wr_ptr + (w_wr_ok ? AW'(w_wr_num) : AW'(0));
            r_rd_ptr <= r_rd_ptr + AW'(w_pop_num);
            r_count  <= r_count - CW'(w_pop_num) + (w_wr_ok ? CW'(w_wr_num) : CW'(0));
            r_rdvld  <= w_rd_vld;
            for (int p = 0; p < DFI_PHASES; p++) begin
                if (w_rd_vld[p]) begin
                    r_rddata[p] <= w_pop_hit[p] ? r_mem[w_rd_addr[p]] : {NB{DFI_UNDERFLOW_BYTE}};
                end
            end
            if (!w_wr_ok) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_underflow) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign dfi_rddata_0_p0       = r_rddata[0];
    assign dfi_rddata_0_p1       = r_rddata[1];
    assign dfi_rddata_1_p2       = r_rddata[2];
    assign dfi_rddata_1_p3       = r_rddata[3];
    assign dfi_rddata_valid_0_p0 = r_rdvld[0];
    assign dfi_rddata_valid_0_p1 = r_rdvld[1];
    assign dfi_rddata_valid_1_p2 = r_rdvld[2];
    assign dfi_rddata_valid_1_p3 = r_rdvld[3];
    assign fifo_count            = r_count;
    assign overflow_err          = r_overflow;
    assign underflow_err         = r_underflow;

endmodule

// File: tb/tb_openddr_dfi_phy_responder.sv
// tb/tb_openddr_dfi_phy_responder.sv - scoreboard bench for the DFI PHY loopback responder
module tb_openddr_dfi_phy_responder;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int MAXL  = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [3:0]      cfg_rdlat;
    logic            err_clr;
    logic [DW-1:0]   wd [4];
    logic [DW/8-1:0] wm [4];
    logic [3:0]      we;
    logic [3:0]      re;

    wire [4*DW-1:0]  rdb;
    wire [3:0]       vld;
    wire [4:0]       fifo_count;
    wire             rd_inflight;
    wire             overflow_err;
    wire             underflow_err;

    openddr_dfi_phy_responder #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .MAX_RDLAT  (MAXL)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cfg_rdlat             (cfg_rdlat),
        .err_clr               (err_clr),
        .dfi_wrdata_0_p0       (wd[0]),
        .dfi_wrdata_0_p1       (wd[1]),
        .dfi_wrdata_1_p2       (wd[2]),
        .dfi_wrdata_1_p3       (wd[3]),
        .dfi_wrdata_mask_0_p0  (wm[0]),
        .dfi_wrdata_mask_0_p1  (wm[1]),
        .dfi_wrdata_mask_1_p2  (wm[2]),
        .dfi_wrdata_mask_1_p3  (wm[3]),
        .dfi_wrdata_en_0_p0    (we[0]),
        .dfi_wrdata_en_0_p1    (we[1]),
        .dfi_wrdata_en_1_p2    (we[2]),
        .dfi_wrdata_en_1_p3    (we[3]),
        .dfi_rddata_en_0_p0    (re[0]),
        .dfi_rddata_en_0_p1    (re[1]),
        .dfi_rddata_en_1_p2    (re[2]),
        .dfi_rddata_en_1_p3    (re[3]),
        .dfi_rddata_0_p0       (rdb[0*DW +: DW]),
        .dfi_rddata_0_p1       (rdb[1*DW +: DW]),
        .dfi_rddata_1_p2       (rdb[2*DW +: DW]),
        .dfi_rddata_1_p3       (rdb[3*DW +: DW]),
        .dfi_rddata_valid_0_p0 (vld[0]),
        .dfi_rddata_valid_0_p1 (vld[1]),
        .dfi_rddata_valid_1_p2 (vld[2]),
        .dfi_rddata_valid_1_p3 (vld[3]),
        .fifo_count            (fifo_count),
        .rd_inflight           (rd_inflight),
        .overflow_err          (overflow_err),
        .underflow_err         (underflow_err)
    );

    typedef struct {
        int         due;
        logic [3:0] v;
    } pend_t;

    typedef struct {
        logic [3:0]    v;
        logic [DW-1:0] d [4];
    } exp_t;

    logic [DW-1:0] mq [$];
    pend_t         pend [$];
    exp_t          sb [$];
    int            edge_no = 0;
    int            m_rdlat = 1;
    bit            m_ovf = 0;
    bit            m_unf = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [4*DW-1:0] act, input logic [4*DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int clamp_lat(input logic [3:0] c);
        if (c == 0) return 1;
        if (int'(c) > MAXL) return MAXL;
        return int'(c);
    endfunction

    function automatic logic [DW-1:0] masked(input logic [DW-1:0] d, input logic [DW/8-1:0] m);
        logic [DW-1:0] r;
        r = d;
        for (int b = 0; b < DW/8; b++) begin
            if (m[b]) r[8*b +: 8] = 8'h00;
        end
        return r;
    endfunction

    // Reference behaviour for one clock edge, using the inputs that were stable across it.
    task automatic model_edge();
        int   start;
        int   n;
        bit   busy;
        bit   drop;
        bit   unf;
        exp_t e;
        edge_no++;
        if (rst) begin
            mq.delete();
            pend.delete();
            sb.delete();
            m_rdlat = 1;
            m_ovf   = 0;
            m_unf   = 0;
            return;
        end
        start = mq.size();
        busy  = pend.size() > 0;
        unf   = 0;
        if (busy && pend[0].due == edge_no) begin
            e.v = pend[0].v;
            for (int p = 0; p < 4; p++) begin
                e.d[p] = '0;
                if (e.v[p]) begin
                    if (mq.size() > 0) begin
                        e.d[p] = mq.pop_front();
                    end else begin
                        e.d[p] = {(DW/8){8'hEE}};
                        unf    = 1;
                    end
                end
            end
            void'(pend.pop_front());
            sb.push_back(e);
        end
        n    = $countones(we);
        drop = n > (DEPTH - start);
        if (!drop) begin
            for (int p = 0; p < 4; p++) begin
                if (we[p]) mq.push_back(masked(wd[p], wm[p]));
            end
        end
        if (re != 0) begin
            pend.push_back('{edge_no + m_rdlat, re});
        end else if (!busy) begin
            m_rdlat = clamp_lat(cfg_rdlat);
        end
        m_ovf = drop ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
        m_unf = unf  ? 1'b1 : (err_clr ? 1'b0 : m_unf);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        chk("fifo_count", fifo_count, mq.size());
        chk("overflow_err", overflow_err, m_ovf);
        chk("underflow_err", underflow_err, m_unf);
        chk("rd_inflight", rd_inflight, pend.size() > 0);
    endtask

    task automatic idle();
        we      = '0;
        re      = '0;
        err_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (vld != 0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid actual %b required 0000 (t=%0t)", vld, $time);
            end else begin
                e = sb.pop_front();
                chk("sb_valid", vld, e.v);
                for (int p = 0; p < 4; p++) begin
                    if (e.v[p]) chk($sformatf("sb_data_p%0d", p), rdb[p*DW +: DW], e.d[p]);
                end
            end
        end else if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_valid actual 0000 required %b (t=%0t)", e.v, $time);
        end
    end

    initial begin
        rst       = 1'b1;
        cfg_rdlat = 4'd1;
        for (int p = 0; p < 4; p++) begin
            wd[p] = '0;
            wm[p] = '0;
        end
        idle();
        step();
        step();
        chk("reset_rddata", rdb, '0);
        chk("reset_valid", vld, 4'b0000);
        rst = 1'b0;

        // Four phases in, one four-phase read back at latency 3.
        cfg_rdlat = 4'd3;
        we = 4'b1111;
        wd[0] = {8{8'h11}};
        wd[1] = {8{8'h22}};
        wd[2] = {8{8'h33}};
        wd[3] = {8{8'h44}};
        step();
        chk("plan1_count_full", fifo_count, 4);
        idle();
        re = 4'b1111;
        step();
        idle();
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("plan1_valid_c%0d", i), vld, (i == 3) ? 4'b1111 : 4'b0000);
        end
        chk("plan1_data", rdb, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
        chk("plan1_count_empty", fifo_count, 0);

        // Byte masking at latency 1.
        cfg_rdlat = 4'd1;
        we = 4'b0001;
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wm[0] = 8'h0F;
        step();
        idle();
        wm[0] = '0;
        re = 4'b0001;
        step();
        idle();
        step();
        chk("plan2_valid", vld, 4'b0001);
        chk("plan2_data", rdb[0 +: DW], 64'hFFFF_FFFF_0000_0000);

        // All-or-nothing overflow, then clear.
        for (int i = 0; i < 4; i++) begin
            we = (i == 3) ? 4'b0011 : 4'b1111;
            for (int p = 0; p < 4; p++) wd[p] = {$urandom, $urandom};
            step();
        end
        we = 4'b1111;
        step();
        chk("plan3_count_held", fifo_count, 14);
        chk("plan3_overflow_set", overflow_err, 1'b1);
        idle();
        err_clr = 1'b1;
        step();
        chk("plan3_overflow_clr", overflow_err, 1'b0);
        idle();

        // Drain to one entry, then read two phases to starve p1.
        for (int i = 0; i < 4; i++) begin
            re = (i == 3) ? 4'b0001 : 4'b1111;
            step();
        end
        idle();
        step();
        step();
        chk("plan4_one_left", fifo_count, 1);
        re = 4'b0011;
        step();
        idle();
        step();
        chk("plan4_valid", vld, 4'b0011);
        chk("plan4_fill", rdb[DW +: DW], 64'hEEEE_EEEE_EEEE_EEEE);
        chk("plan4_underflow", underflow_err, 1'b1);
        err_clr = 1'b1;
        step();
        idle();

        // Latency change while reads are in flight.
        cfg_rdlat = 4'd5;
        we = 4'b1111;
        for (int p = 0; p < 4; p++) wd[p] = {$urandom, $urandom};
        step();
        idle();
        re = 4'b0001;
        step();
        re = 4'b0010;
        cfg_rdlat = 4'd2;
        step();
        idle();
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("plan5_old_lat_c%0d", k), vld,
                (k == 4) ? 4'b0001 : ((k == 5) ? 4'b0010 : 4'b0000));
        end
        step();
        re = 4'b0100;
        step();
        idle();
        for (int k = 1; k <= 2; k++) begin
            step();
            chk($sformatf("plan5_new_lat_c%0d", k), vld, (k == 2) ? 4'b0100 : 4'b0000);
        end

        // Reset with reads in flight.
        cfg_rdlat = 4'd4;
        step();
        re = 4'b1111;
        step();
        idle();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("plan6_rddata", rdb, '0);
        chk("plan6_count", fifo_count, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("plan6_no_valid_c%0d", k), vld, 4'b0000);
        end

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            we = 4'($urandom);
            for (int p = 0; p < 4; p++) begin
                wd[p] = {$urandom, $urandom};
                wm[p] = ($urandom_range(0, 1) == 0) ? '0 : 8'($urandom);
            end
            re        = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            err_clr   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 31) == 0) cfg_rdlat = 4'($urandom);
            step();
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 20; i++) step();
        chk("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/openddr_dfi_phy_responder.md
Name: openddr_dfi_phy_responder

Overview:
PHY-side counterpart of the controller DFI data path: sinks the 4-phase DFI write-data interface and sources the 4-phase DFI read-data interface. Write beats, with masked bytes zeroed, are queued in a loopback FIFO. Read-enable phases are returned as read-valid phases with FIFO data after a programmable read latency. It serves as the synthesizable PHY stand-in for controller bring-up, FPGA loopback and regression benches.

Parameters:
DATA_WIDTH, 64, bits per phase beat; multiple of 8
DEPTH, 16, loopback FIFO entries; power of 2, >= 4
MAX_RDLAT, 15, maximum read latency in clk cycles

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_rdlat  in  4  read latency in cycles; 0 treated as 1; values above MAX_RDLAT clamp to MAX_RDLAT
err_clr  in  1  clears sticky error flags
dfi_wrdata_0_p0/0_p1/1_p2/1_p3  in  DATA_WIDTH each  write beats, phases 0..3
dfi_wrdata_mask_0_p0/0_p1/1_p2/1_p3  in  DATA_WIDTH/8 each  byte masks; 1 = byte masked
dfi_wrdata_en_0_p0/0_p1/1_p2/1_p3  in  1 each  per-phase write enable
dfi_rddata_en_0_p0/0_p1/1_p2/1_p3  in  1 each  per-phase read request
dfi_rddata_0_p0/0_p1/1_p2/1_p3  out  DATA_WIDTH each  read beats
dfi_rddata_valid_0_p0/0_p1/1_p2/1_p3  out  1 each  per-phase read valid
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy
rd_inflight  out  1  any read enable inside the latency pipe
overflow_err  out  1  sticky write-drop flag
underflow_err  out  1  sticky read-starve flag

Behaviour:
- Reset (rst=1 at a clk edge): FIFO empty, fifo_count=0; all rddata outputs 0, all valids 0; errors 0; delay pipe cleared; rd_inflight=0; latched latency rdlat_q=1. Reset mid-operation discards queued data and in-flight reads, with no valid pulses afterwards.
- Write capture, same edge as en: stored beat = wrdata with each masked byte forced to 8'h00.
  - Push order within a cycle: p0, p1, p2, p3, for enabled phases only.
  - Writes of one cycle are all-or-nothing: if popcount(wr_en) exceeds the free space at cycle start, all of that cycle's beats are dropped, FIFO is unchanged, and overflow_err is set.
- Read latency:
  - rdlat_q loads the clamped cfg_rdlat on every cycle where the pipe is empty and no rddata_en bit is high. Otherwise rdlat_q holds, so changes while reads are in flight take effect only once the pipe drains.
  - A rd_en vector sampled at edge k appears as the matching valid vector registered at edge k+rdlat_q, so it is visible from k+rdlat_q. rdlat_q=1 means one register stage.
  - Back-to-back rd_en vectors every cycle are supported.
- Read data pop: happens on the edge the valids are registered. Beats for phases p0..p3 with valid bits set are popped in order.
  - Pops see occupancy at cycle start; same-cycle pushes are not visible.
  - A phase that finds no entry still asserts valid, drives the fill pattern (bytes 8'hEE), and sets underflow_err. Entries popped by earlier phases of the same cycle are consumed normally.
- Concurrent push and pop: next count = count - pops + accepted pushes. Pointers wrap modulo DEPTH.
- Non-valid phases: rddata holds its previous value.
- rd_inflight is high while any pipe stage holds a nonzero vector.
- Errors stay set until err_clr or rst. If err_clr and a new error occur in the same cycle, the error flag ends set.

Decomposition:
- openddr_pkg gains: DFI_PHASES=4, DFI_UNDERFLOW_BYTE=8'hEE, DFI_MASK_FILL_BYTE=8'h00, and a typedef for the 4-bit phase vector.
- Sub-module openddr_dfi_rdlat_delay: variable-tap shift register of phase vectors, outputs delayed vector and inflight.
- FIFO and mask merge stay in the top level.

Test Plan:
- Writes on all 4 phases of words 0x11..11, 0x22..22, 0x33..33, 0x44..44, masks 0; then rd_en=4'b1111 with cfg_rdlat=3 -> valids 4'b1111 exactly 3 cycles later, data in order, fifo_count 4->0.
- Write 0xFFFF_FFFF_FFFF_FFFF on p0 with mask 8'h0F, then p0 read at rdlat=1 -> data 0xFFFF_FFFF_0000_0000, valid one cycle after en.
- Fill FIFO to 14 (DEPTH=16), then 4-phase write -> all 4 dropped, count stays 14, overflow_err=1; err_clr -> flag clears.
- Empty FIFO with one entry queued, rd_en=4'b0011 -> p0 returns the entry, p1 returns 0xEEEE_EEEE_EEEE_EEEE with valid 1, underflow_err=1.
- rdlat=5, issue reads, change cfg_rdlat to 2 at cycle+1 -> in-flight reads return at latency 5; new reads after drain return at latency 2.
- rst asserted 2 cycles after rd_en with rdlat=4 -> no valid ever asserted, fifo_count=0, all outputs 0.
